// File: rtl/fp_conv_pkg.sv
// -----------------------------------------------------------------------------
// fp_conv_pkg
// Shared definitions for the integer-to-float conversion path.
//   state_t           : control state encoding of int_magnitude_normalizer
//   DEFAULT_WIDTH     : default integer operand width
//   FP32_BIAS/FP64_BIAS : exponent biases used by the FCVT consumer, which
//                       forms exponent = bias + WIDTH-1 - out_lzc
// -----------------------------------------------------------------------------
package fp_conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ABS  = 2'd1,
      ST_NORM = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 64;
   localparam int FP32_BIAS     = 127;
   localparam int FP64_BIAS     = 1023;

endpackage

// File: rtl/int_magnitude_normalizer_if.sv
// -----------------------------------------------------------------------------
// int_magnitude_normalizer_if
// Operand and result handshake bundle of int_magnitude_normalizer.
//   in_valid/in_ready   : operand handshake (in_value, in_signed)
//   out_valid/out_ready : result handshake (out_sign, out_mant, out_lzc,
//                         out_zero)
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The sender holds valid and its data stable until
// that edge; ready may change freely and is not a promise for future cycles.
// Modports: slave = the normalizer, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface int_magnitude_normalizer_if #(
   parameter int WIDTH = 64
);
   localparam int LZW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_value;
   logic             in_signed;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mant;
   logic [LZW-1:0]   out_lzc;
   logic             out_zero;

   modport slave (
      input  in_valid, in_value, in_signed, out_ready,
      output in_ready, out_valid, out_sign, out_mant, out_lzc, out_zero
   );

   modport master (
      output in_valid, in_value, in_signed, out_ready,
      input  in_ready, out_valid, out_sign, out_mant, out_lzc, out_zero
   );

endinterface

// File: rtl/int_abs_unit.sv
// -----------------------------------------------------------------------------
// int_abs_unit
// Combinational sign/magnitude split of an integer operand.
//   i_value       : operand
//   i_signed_mode : 1 = two's-complement, 0 = unsigned
//   o_sign        : operand is negative (signed mode only)
//   o_mag         : absolute value; the most-negative value maps onto
//                   1 followed by zeros, which is its correct unsigned magnitude
// -----------------------------------------------------------------------------
module int_abs_unit #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_signed_mode,
   output logic             o_sign,
   output logic [WIDTH-1:0] o_mag
);

   logic [WIDTH-1:0] w_neg;

   assign o_sign = i_signed_mode & i_value[WIDTH-1];
   assign w_neg  = ~i_value + {{(WIDTH-1){1'b0}}, 1'b1};
   assign o_mag  = o_sign ? w_neg : i_value;

endmodule

// File: rtl/int_magnitude_normalizer.sv
// -----------------------------------------------------------------------------
// int_magnitude_normalizer
// Multi-cycle converter: integer -> sign + left-normalized magnitude +
// leading-zero count, one operand in flight at a time.
//   clk, reset  : single clock, synchronous active-high reset
//   bus (slave) : operand/result handshakes, see int_magnitude_normalizer_if
//   o_dbg_state : current control state
// Optional build macro INT_MAGNITUDE_NIBBLE_SHIFT_EN: NORM shifts by 4 when the
// top nibble is zero, shortening latency; results are unchanged.
// -----------------------------------------------------------------------------
module int_magnitude_normalizer
   import fp_conv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic   clk,
   input  logic   reset,
   int_magnitude_normalizer_if.slave bus,
   output state_t o_dbg_state
);

   localparam int LZW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_next_state;
   logic             w_in_ready;
   logic             w_norm_done;

   logic [WIDTH-1:0] r_value;
   logic             r_signed;
   logic [WIDTH-1:0] r_mag;
   logic [LZW-1:0]   r_lzc;
   logic             r_sign;
   logic             r_zero;

   logic             r_out_sign;
   logic [WIDTH-1:0] r_out_mant;
   logic [LZW-1:0]   r_out_lzc;
   logic             r_out_zero;

   logic             w_abs_sign;
   logic [WIDTH-1:0] w_abs_mag;

   int_abs_unit #(.WIDTH(WIDTH)) u_abs (
      .i_value       (r_value),
      .i_signed_mode (r_signed),
      .o_sign        (w_abs_sign),
      .o_mag         (w_abs_mag)
   );

   // A zero operand also passes through one NORM cycle, so zero and
   // already-normalized operands share the same minimum latency.
   assign w_norm_done = r_zero | r_mag[WIDTH-1];

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = ~reset;
            if (bus.in_valid) w_next_state = ST_ABS;
         end
         ST_ABS:  w_next_state = ST_NORM;
         ST_NORM: if (w_norm_done) w_next_state = ST_DONE;
         ST_DONE: if (bus.out_ready) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_value    <= '0;
         r_signed   <= 1'b0;
         r_mag      <= '0;
         r_lzc      <= '0;
         r_sign     <= 1'b0;
         r_zero     <= 1'b0;
         r_out_sign <= 1'b0;
         r_out_mant <= '0;
         r_out_lzc  <= '0;
         r_out_zero <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_value  <= bus.in_value;
                  r_signed <= bus.in_signed;
               end
            end
            ST_ABS: begin
               r_sign <= w_abs_sign;
               r_mag  <= w_abs_mag;
               r_zero <= (w_abs_mag == '0);
               r_lzc  <= (w_abs_mag == '0) ? LZW'(WIDTH) : '0;
            end
            ST_NORM: begin
               if (w_norm_done) begin
                  // Result registers are separate so they keep the previous
                  // result while the next operand is being normalized.
                  r_out_sign <= r_sign;
                  r_out_mant <= r_mag;
                  r_out_lzc  <= r_lzc;
                  r_out_zero <= r_zero;
`ifdef INT_MAGNITUDE_NIBBLE_SHIFT_EN
               end else if (r_mag[WIDTH-1 -: 4] == 4'd0) begin
                  r_mag <= r_mag << 4;
                  r_lzc <= r_lzc + LZW'(4);
`endif
               end else begin
                  r_mag <= r_mag << 1;
                  r_lzc <= r_lzc + LZW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_sign  = r_out_sign;
   assign bus.out_mant  = r_out_mant;
   assign bus.out_lzc   = r_out_lzc;
   assign bus.out_zero  = r_out_zero;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_int_magnitude_normalizer.sv
// -----------------------------------------------------------------------------
// tb_int_magnitude_normalizer
// Directed and randomized operands for int_magnitude_normalizer (WIDTH=64),
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_int_magnitude_normalizer;
   import fp_conv_pkg::*;

   localparam int W = 64;

   typedef struct packed {
      logic          sign;
      logic [W-1:0]  mant;
      logic [31:0]   lzc;
      logic          zero;
      logic [31:0]   lat;
   } exp_t;

   logic   clk;
   logic   reset;
   state_t dbg_state;
   int     n_vec;
   int     n_fail;

   int_magnitude_normalizer_if #(.WIDTH(W)) bus ();

   int_magnitude_normalizer #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic exp_t model(input logic [W-1:0] v, input logic s);
      exp_t         e;
      logic [W-1:0] mag;
      e.sign = s && (v >= 64'h8000_0000_0000_0000);
      mag    = e.sign ? (64'd0 - v) : v;
      e.zero = (mag == 64'd0);
      e.lzc  = W;
      for (int i = W - 1; i >= 0; i--) begin
         if (mag[i]) begin
            e.lzc = W - 1 - i;
            break;
         end
      end
      e.mant = e.zero ? 64'd0 : (mag << e.lzc);
`ifdef INT_MAGNITUDE_NIBBLE_SHIFT_EN
      e.lat = e.zero ? 2 : 2 + e.lzc / 4 + e.lzc % 4;
`else
      e.lat = e.zero ? 2 : 2 + e.lzc;
`endif
      return e;
   endfunction

   // ---------------- comparison ----------------
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".sign"},  64'(bus.out_sign),  64'(e.sign));
      check({tag, ".mant"},  bus.out_mant,       e.mant);
      check({tag, ".lzc"},   64'(bus.out_lzc),   64'(e.lzc));
      check({tag, ".zero"},  64'(bus.out_zero),  64'(e.zero));
      check({tag, ".busy_rdy"}, 64'(bus.in_ready), 64'd0);
   endtask

   // ---------------- driver ----------------
   // Offers one operand, measures latency, holds out_ready low for 'hold'
   // cycles in DONE, then completes the output handshake.
   task automatic run_op(input string tag, input logic [W-1:0] v, input logic s, input int hold);
      exp_t e;
      int   lat;
      e = model(v, s);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_value  = v;
      bus.in_signed = s;
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_value  = {$urandom, $urandom};
      bus.in_signed = 1'($urandom);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid) break;
         bus.out_ready = 1'($urandom);
      end
      check({tag, ".latency"}, 64'(lat), 64'(e.lat));
      bus.out_ready = 1'b0;
      if (bus.out_valid) begin
         check_outputs(tag, e);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_outputs({tag, ".hold"}, e);
         end
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.out_ready = 1'b0;
         check({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
         check({tag, ".ready_back"}, 64'(bus.in_ready), 64'd1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] v;
      int           sh;
      n_vec         = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_value  = '0;
      bus.in_signed = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.in_ready",  64'(bus.in_ready),  64'd0);
      check("rst.out_valid", 64'(bus.out_valid), 64'd0);
      check("rst.out_mant",  bus.out_mant,       64'd0);
      check("rst.out_lzc",   64'(bus.out_lzc),   64'd0);
      check("rst.state",     64'(dbg_state),     64'(ST_IDLE));
      reset = 1'b0;
      #1;
      check("rst.ready_after", 64'(bus.in_ready), 64'd1);

      // directed corner operands
      run_op("neg_one",     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
      run_op("u_all_ones",  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
      run_op("s_min",       64'h8000_0000_0000_0000, 1'b1, 0);
      run_op("s_0c00",      64'h0000_0000_0000_0C00, 1'b1, 0);
      run_op("zero_s",      64'd0,                   1'b1, 0);
      run_op("zero_u",      64'd0,                   1'b0, 0);
      run_op("u_one",       64'd1,                   1'b0, 0);
      run_op("s_max",       64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
      // backpressure, then back-to-back accept on the following cycle
      run_op("bp",          64'hFFFF_FFFF_FFFF_FB2E, 1'b1, 5);
      run_op("bp_next",     64'h0000_0123_4567_89AB, 1'b0, 0);

      // reset in the middle of NORM
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_value  = 64'd1;
      bus.in_signed = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("mid.state_norm", 64'(dbg_state), 64'(ST_NORM));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid.out_valid", 64'(bus.out_valid), 64'd0);
      check("mid.out_sign",  64'(bus.out_sign),  64'd0);
      check("mid.out_mant",  bus.out_mant,       64'd0);
      check("mid.out_lzc",   64'(bus.out_lzc),   64'd0);
      check("mid.out_zero",  64'(bus.out_zero),  64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid.ready_after", 64'(bus.in_ready), 64'd1);
      run_op("after_rst", 64'hFFFF_FFFF_FFFF_FF00, 1'b1, 1);

      // randomized operands spread over all leading-zero counts
      for (int n = 0; n < 40; n++) begin
         v  = {$urandom, $urandom};
         sh = $urandom_range(0, 64);
         v  = (sh == 64) ? 64'd0 : (v >> sh);
         if ($urandom_range(0, 3) == 0) v = 64'd0 - v;
         run_op("rand", v, 1'($urandom), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
